defuse_seq_check: RTL and testbench
===================================

DEFUSE_SEQ_CHECK -- requirements
Module: defuse_seq_check

Interface
REQ-001 SHALL have parameter: SEQ_LEN, 4, number of 2-bit codes in a defuse sequence.
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 1000, CLOCK cycles allowed in ARMED before detonation (minimum 2).
REQ-003 SHALL have port: CLOCK  input  1  single system clock; all state updates on the rising edge.
REQ-004 SHALL have port: RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: RANDOM  input  2  free-running random code from the LFSR RNG stage, which this block consumes.
REQ-006 SHALL have port: ARM_N  input  1  active-low arm button, asynchronous to CLOCK and already debounced.
REQ-007 SHALL have port: PRESS_VALID  input  1  one-cycle strobe marking a player wire-cut attempt.
REQ-008 SHALL have port: PRESS_CODE  input  2  wire code of the attempt; sampled only when PRESS_VALID=1.
REQ-009 SHALL have port: ARMED  output  1  high while in ARMED.
REQ-010 SHALL have port: DEFUSED  output  1  high while in DEFUSED.
REQ-011 SHALL have port: EXPLODED  output  1  high while in EXPLODED.
REQ-012 SHALL have port: STEP  output  3  count of correct presses so far, 0..SEQ_LEN.
REQ-013 SHALL have port: SEQ_OUT  output  2*SEQ_LEN  captured sequence; seq[i] occupies bits [2i+1:2i].

Function
REQ-014 SHALL synchronize ARM_N through two flops, then detect its falling edge; the edge yields exactly one arm event per press.
REQ-015 SHALL implement the states IDLE, LOAD, ARMED, DEFUSED and EXPLODED.
REQ-016 SHALL, on an arm event in IDLE, DEFUSED or EXPLODED, go to LOAD, clear STEP to 0, clear the timeout counter and clear SEQ_OUT.
REQ-017 SHALL, in LOAD, sample RANDOM into seq[0], seq[1], ... on SEQ_LEN consecutive cycles, starting the cycle after the arm event.
REQ-018 SHALL enter ARMED on the cycle after the last sample; arm-to-ARMED latency is SEQ_LEN+1 cycles after the synchronized edge.
REQ-019 SHALL ignore arm events while in LOAD or ARMED.
REQ-020 SHALL ignore PRESS_VALID in every state except ARMED.
REQ-021 SHALL, in ARMED with PRESS_VALID=1 and PRESS_CODE == seq[STEP], increment STEP; when the new STEP equals SEQ_LEN, it SHALL go to DEFUSED.
REQ-022 SHALL, in ARMED with PRESS_VALID=1 and PRESS_CODE != seq[STEP], go to EXPLODED with STEP held.
REQ-023 SHALL increment the timeout counter every cycle in ARMED; on the cycle it reaches TIMEOUT_CYCLES-1, it SHALL go to EXPLODED.
REQ-024 SHALL give timeout priority when timeout and a correct final press occur in the same cycle, with the result EXPLODED.
REQ-025 SHALL treat DEFUSED and EXPLODED as terminal; only an arm event or RESET leaves them.
REQ-026 SHALL drive all outputs from registers with no combinational path from inputs to outputs; an input's effect appears on outputs one cycle after the sampling edge.
REQ-027 SHALL hold SEQ_OUT constant from the end of LOAD until the next arm event.

Reset
REQ-028 SHALL, while RESET=0, immediately force state IDLE, ARMED=DEFUSED=EXPLODED=0, STEP=0, SEQ_OUT=0, the timeout counter to 0 and the synchronizer flops to 1 (button released).
REQ-029 SHALL abort LOAD or ARMED on a mid-operation reset, with no partial sequence retained.
REQ-030 SHALL not produce a false arm event on reset release while ARM_N is held low.

Structure
REQ-031 SHALL take the state encoding enum, the SEQ_LEN default and the code width (2) from shared package defuse_pkg.
REQ-032 SHALL implement the 2-flop synchronizer and falling-edge detector as sub-module button_edge_n, reusable by other game stages.
REQ-033 SHALL size the timeout counter as $clog2(TIMEOUT_CYCLES) bits.

Verification
REQ-034 SHALL cover capture and defuse: RANDOM driven 2,1,3,0 on the LOAD cycles, ARM_N pulsed low -> SEQ_OUT=8'b00_11_01_10 and ARMED=1; presses 2,1,3,0 -> STEP steps 1..4, DEFUSED=1 on the cycle after the 4th press.
REQ-035 SHALL cover a wrong press: same sequence, presses 2 then 3 -> STEP=1, EXPLODED=1, ARMED=0; a later PRESS_VALID leaves all outputs unchanged.
REQ-036 SHALL cover timeout: TIMEOUT_CYCLES=20, arm and make no presses -> EXPLODED=1 exactly 20 cycles after ARMED rises; a correct final press on cycle 19 still yields EXPLODED.
REQ-037 SHALL cover re-arm: from EXPLODED, press ARM_N -> LOAD, STEP=0, new SEQ_OUT captured, ARMED=1 after SEQ_LEN+1 cycles; an ARM_N press during ARMED changes nothing.
REQ-038 SHALL cover reset mid-LOAD: RESET=0 after 2 samples -> all outputs 0 immediately; release with ARM_N low -> stays IDLE.
REQ-039 SHALL cover a long hold: ARM_N held low 50 cycles -> exactly one LOAD sequence.

Source files
------------

// File: rtl/defuse_pkg.sv
// Shared definitions for the defuse game stages.
//   CODE_W      : width of one wire code
//   SEQ_LEN_DEF : default number of codes in a defuse sequence
//   STEP_W      : width of the STEP progress output
//   state_e     : state encoding of defuse_seq_check
package defuse_pkg;

  localparam int CODE_W      = 2;
  localparam int SEQ_LEN_DEF = 4;
  localparam int STEP_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_DEFUSED  = 3'd3,
    ST_EXPLODED = 3'd4
  } state_e;

endpackage

// File: rtl/button_edge_n.sv
// Two-flop synchronizer plus falling-edge detector for an active-low,
// already-debounced button that is asynchronous to clk_i.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   btn_ni : raw active-low button level
//   fall_o : one-cycle pulse per press (high-to-low of the synchronized level)
module button_edge_n (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic fall_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [2:0] rdy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      rdy_q   <= '0;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rdy_q   <= {rdy_q[1:0], 1'b1};
    end
  end

  // The "released" reset value does not reflect the real button level until a
  // true sample has reached prev_q (three edges). Gating on rdy_q[2] stops a
  // button held low through reset release from looking like a fresh press.
  assign fall_o = rdy_q[2] & prev_q & ~sync2_q;

endmodule

// File: rtl/defuse_seq_check.sv
// Defuse sequence checker: captures SEQ_LEN random codes on arm, then checks
// player wire-cut attempts against them under a timeout.
//   CLOCK       : system clock, rising edge
//   RESET       : asynchronous active-low reset
//   RANDOM      : free-running random code, sampled during LOAD
//   ARM_N       : active-low arm button (asynchronous, debounced)
//   PRESS_VALID : one-cycle wire-cut strobe
//   PRESS_CODE  : code of the attempt
//   ARMED/DEFUSED/EXPLODED : registered state flags
//   STEP        : correct presses so far
//   SEQ_OUT     : captured sequence, seq[i] at bits [2i+1:2i]
//
// state       | meaning
// ST_IDLE     | waiting for first arm after reset
// ST_LOAD     | sampling RANDOM into seq[0..SEQ_LEN-1], one per cycle
// ST_ARMED    | accepting presses, timeout running
// ST_DEFUSED  | full sequence entered in time (terminal until re-arm)
// ST_EXPLODED | wrong press or timeout (terminal until re-arm)
module defuse_seq_check
  import defuse_pkg::*;
#(
  parameter int SEQ_LEN        = SEQ_LEN_DEF,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [CODE_W-1:0]         RANDOM,
  input  logic                      ARM_N,
  input  logic                      PRESS_VALID,
  input  logic [CODE_W-1:0]         PRESS_CODE,
  output logic                      ARMED,
  output logic                      DEFUSED,
  output logic                      EXPLODED,
  output logic [STEP_W-1:0]         STEP,
  output logic [CODE_W*SEQ_LEN-1:0] SEQ_OUT
);

  localparam int                TO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(SEQ_LEN - 1);
  localparam logic [STEP_W-1:0] SEQ_END  = STEP_W'(SEQ_LEN);

  state_e                           state_q, state_d;
  logic [STEP_W-1:0]                step_q, step_d;
  logic [STEP_W-1:0]                ld_q, ld_d;
  logic [TO_W-1:0]                  to_q, to_d;
  logic [SEQ_LEN-1:0][CODE_W-1:0]   seq_q, seq_d;
  logic                             armed_q, defused_q, exploded_q;
  logic                             arm_evt;
  logic [CODE_W-1:0]                want_code;
  logic [STEP_W-1:0]                step_inc;

  button_edge_n u_arm_edge (
    .clk_i  (CLOCK),
    .rst_ni (RESET),
    .btn_ni (ARM_N),
    .fall_o (arm_evt)
  );

  // Code expected for the next press; mux avoids an oversized array index.
  always_comb begin
    want_code = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (step_q == STEP_W'(i)) want_code = seq_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    ld_d     = ld_q;
    to_d     = to_q;
    seq_d    = seq_q;
    step_inc = step_q + STEP_W'(1);
    case (state_q)
      ST_IDLE, ST_DEFUSED, ST_EXPLODED: begin
        if (arm_evt) begin
          state_d = ST_LOAD;
          step_d  = '0;
          ld_d    = '0;
          to_d    = '0;
          seq_d   = '0;
        end
      end
      ST_LOAD: begin
        for (int i = 0; i < SEQ_LEN; i++) begin
          if (ld_q == STEP_W'(i)) seq_d[i] = RANDOM;
        end
        ld_d = ld_q + STEP_W'(1);
        if (ld_q == LAST_IDX) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        to_d = to_q + TO_W'(1);
        // Timeout wins over any press in the same cycle, STEP is frozen.
        if (to_q == TO_LAST) begin
          state_d = ST_EXPLODED;
        end else if (PRESS_VALID) begin
          if (PRESS_CODE == want_code) begin
            step_d = step_inc;
            if (step_inc == SEQ_END) state_d = ST_DEFUSED;
          end else begin
            state_d = ST_EXPLODED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      ld_q       <= '0;
      to_q       <= '0;
      seq_q      <= '0;
      armed_q    <= 1'b0;
      defused_q  <= 1'b0;
      exploded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ld_q       <= ld_d;
      to_q       <= to_d;
      seq_q      <= seq_d;
      armed_q    <= (state_d == ST_ARMED);
      defused_q  <= (state_d == ST_DEFUSED);
      exploded_q <= (state_d == ST_EXPLODED);
    end
  end

  assign ARMED    = armed_q;
  assign DEFUSED  = defused_q;
  assign EXPLODED = exploded_q;
  assign STEP     = step_q;
  assign SEQ_OUT  = seq_q;

endmodule

// File: tb/tb_defuse_seq_check.sv
module tb_defuse_seq_check;

  localparam int TO = 20;

  logic       CLOCK;
  logic       RESET;
  logic [1:0] RANDOM;
  logic       ARM_N;
  logic       PRESS_VALID;
  logic [1:0] PRESS_CODE;
  logic       ARMED, DEFUSED, EXPLODED;
  logic [2:0] STEP;
  logic [7:0] SEQ_OUT;

  defuse_seq_check #(.SEQ_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .RANDOM      (RANDOM),
    .ARM_N       (ARM_N),
    .PRESS_VALID (PRESS_VALID),
    .PRESS_CODE  (PRESS_CODE),
    .ARMED       (ARMED),
    .DEFUSED     (DEFUSED),
    .EXPLODED    (EXPLODED),
    .STEP        (STEP),
    .SEQ_OUT     (SEQ_OUT)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] step;
    logic       armed;
    logic       defused;
    logic       exploded;
    logic [7:0] seq;
  } exp_t;

  typedef struct {
    logic [7:0] rnd;
    logic [7:0] presses;
    int         np;
    logic [2:0] f_step;
    logic       f_def;
    logic       f_exp;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[5];
  logic [7:0] m_seq;
  logic [2:0] m_step;
  logic       m_def, m_exp;
  logic [7:0] pp;
  int         rises;
  logic       prev_armed;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Press through the scoreboard: expectation from the game model is queued
  // when the press is driven, then popped once the DUT has registered it.
  task automatic press(input logic [1:0] code);
    exp_t e;
    if (!m_def && !m_exp) begin
      if (code == m_seq[2*int'(m_step) +: 2]) begin
        m_step = m_step + 3'd1;
        if (m_step == 3'd4) m_def = 1'b1;
      end else begin
        m_exp = 1'b1;
      end
    end
    e.step     = m_step;
    e.armed    = !(m_def || m_exp);
    e.defused  = m_def;
    e.exploded = m_exp;
    e.seq      = m_seq;
    sb_q.push_back(e);
    PRESS_VALID = 1'b1;
    PRESS_CODE  = code;
    tick();
    PRESS_VALID = 1'b0;
    PRESS_CODE  = 2'($urandom);
    e = sb_q.pop_front();
    chk("sb_step", STEP, e.step);
    chk("sb_armed", ARMED, e.armed);
    chk("sb_defused", DEFUSED, e.defused);
    chk("sb_exploded", EXPLODED, e.exploded);
    chk("sb_seq", SEQ_OUT, e.seq);
  endtask

  task automatic poke(input logic [1:0] code);
    PRESS_VALID = 1'b1;
    PRESS_CODE  = code;
    tick();
    PRESS_VALID = 1'b0;
  endtask

  // Press ARM_N; returns just after the edge where LOAD begins.
  task automatic start_arm();
    ARM_N = 1'b0;
    repeat (3) tick();
    chk("load_clear", {ARMED, DEFUSED, EXPLODED, STEP, SEQ_OUT}, 0);
  endtask

  task automatic load_codes(input logic [7:0] rnd);
    RANDOM = rnd[1:0]; tick();
    RANDOM = rnd[3:2]; tick();
    RANDOM = rnd[5:4]; tick();
    RANDOM = rnd[7:6];
    chk("armed_early", ARMED, 0);
    tick();
    ARM_N  = 1'b1;
    RANDOM = 2'($urandom);
    chk("armed_rise", ARMED, 1);
    chk("seq_capture", SEQ_OUT, rnd);
    chk("step_zero", STEP, 0);
    m_seq = rnd; m_step = 3'd0; m_def = 1'b0; m_exp = 1'b0;
  endtask

  task automatic timeout_race(input int gap, input logic exp_def);
    start_arm();
    load_codes(8'h36);
    poke(2'd2); poke(2'd1); poke(2'd3);
    repeat (gap) tick();
    poke(2'd0);
    chk("race_defused", DEFUSED, exp_def);
    chk("race_exploded", EXPLODED, !exp_def);
    repeat (2) tick();
  endtask

  initial begin
    vecs[0] = '{rnd: 8'h36, presses: 8'h36, np: 4, f_step: 3'd4, f_def: 1'b1, f_exp: 1'b0};
    vecs[1] = '{rnd: 8'h36, presses: 8'h0E, np: 2, f_step: 3'd1, f_def: 1'b0, f_exp: 1'b1};
    vecs[2] = '{rnd: 8'hFF, presses: 8'h3F, np: 4, f_step: 3'd3, f_def: 1'b0, f_exp: 1'b1};
    vecs[3] = '{rnd: 8'h4B, presses: 8'h00, np: 1, f_step: 3'd0, f_def: 1'b0, f_exp: 1'b1};
    vecs[4] = '{rnd: 8'h93, presses: 8'h93, np: 4, f_step: 3'd4, f_def: 1'b1, f_exp: 1'b0};

    RESET = 1'b1; ARM_N = 1'b1; PRESS_VALID = 1'b0; PRESS_CODE = 2'd0; RANDOM = 2'd0;
    #2 RESET = 1'b0;
    #1;
    chk("reset_flags", {ARMED, DEFUSED, EXPLODED}, 0);
    chk("reset_step", STEP, 0);
    chk("reset_seq", SEQ_OUT, 0);
    PRESS_VALID = 1'b1;
    repeat (3) tick();
    PRESS_VALID = 1'b0;
    chk("reset_hold", {ARMED, DEFUSED, EXPLODED, STEP, SEQ_OUT}, 0);
    RESET = 1'b1;
    repeat (4) tick();
    chk("idle_after_reset", {ARMED, DEFUSED, EXPLODED, STEP, SEQ_OUT}, 0);

    for (int v = 0; v < 5; v++) begin
      start_arm();
      load_codes(vecs[v].rnd);
      pp = vecs[v].presses;
      for (int k = 0; k < vecs[v].np; k++) press(pp[2*k +: 2]);
      chk("vec_step", STEP, vecs[v].f_step);
      chk("vec_defused", DEFUSED, vecs[v].f_def);
      chk("vec_exploded", EXPLODED, vecs[v].f_exp);
      press(2'(v));
      repeat (2) tick();
    end

    // Timeout with no presses: EXPLODED exactly TO cycles after ARMED rises.
    start_arm();
    load_codes(8'h36);
    repeat (TO - 1) tick();
    chk("tmo_early_armed", ARMED, 1);
    chk("tmo_early_exploded", EXPLODED, 0);
    tick();
    chk("tmo_exploded", EXPLODED, 1);
    chk("tmo_armed", ARMED, 0);
    repeat (2) tick();

    // Final press on the timeout cycle loses; one cycle earlier it wins.
    timeout_race(16, 1'b0);
    timeout_race(15, 1'b1);

    // ARM_N during ARMED is ignored.
    start_arm();
    load_codes(8'h93);
    press(2'd3);
    ARM_N = 1'b0;
    repeat (4) tick();
    ARM_N = 1'b1;
    repeat (4) tick();
    chk("arm_ign_armed", ARMED, 1);
    chk("arm_ign_step", STEP, 1);
    chk("arm_ign_seq", SEQ_OUT, 8'h93);
    press(2'd0); press(2'd1); press(2'd2);
    repeat (3) tick();

    // Reset in the middle of LOAD, released with ARM_N still low.
    start_arm();
    RANDOM = 2'd2; tick();
    RANDOM = 2'd1; tick();
    chk("partial_seq", SEQ_OUT, 8'h06);
    RESET = 1'b0;
    #1;
    chk("rst_mid_all", {ARMED, DEFUSED, EXPLODED, STEP, SEQ_OUT}, 0);
    RANDOM = 2'd3;
    repeat (2) tick();
    RESET = 1'b1;
    repeat (12) tick();
    chk("rst_no_arm", {ARMED, DEFUSED, EXPLODED, STEP, SEQ_OUT}, 0);
    ARM_N = 1'b1;
    repeat (4) tick();
    start_arm();
    load_codes(8'hC9);
    press(2'd0);
    repeat (3) tick();

    // Long hold of ARM_N: exactly one LOAD, ending in timeout.
    RANDOM = 2'd1;
    ARM_N = 1'b0;
    rises = 0;
    prev_armed = ARMED;
    repeat (50) begin
      tick();
      if (ARMED && !prev_armed) rises++;
      prev_armed = ARMED;
    end
    ARM_N = 1'b1;
    chk("hold_loads", rises, 1);
    chk("hold_exploded", EXPLODED, 1);
    chk("hold_seq", SEQ_OUT, 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
